// File: rtl/alu_calc_core.sv
// Registered ALU calculator core: operand registers A/B, result Y, flags,
// 16 opcodes behind a valid/ready command port, shifts one bit per cycle.
module alu_calc_core #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] din,
  input  logic             dst,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] y_q,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_CMP, OP_AND, OP_OR, OP_XOR,
    OP_NAND, OP_NOR, OP_XNOR, OP_INV, OP_NEG, OP_STO, OP_SWP, OP_LOAD
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             dst_q, dst_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_d, b_d, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum_w, dif_w;
  logic [WIDTH-1:0] res_w, shn_w;
  logic             c_w, v_w, wr_w, shout_w, is_shift_w;

  assign cmd_ready = reset_n & (state_q == S_IDLE) & ~clr;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign flags     = flags_q;

  // Single-cycle ALU result computed from the operand snapshot.
  always_comb begin
    sum_w = {1'b0, opa_q} + {1'b0, opb_q};
    dif_w = {1'b0, opa_q} - {1'b0, opb_q};
    res_w = y_q;
    c_w   = 1'b0;
    v_w   = 1'b0;
    wr_w  = 1'b1;
    unique case (op_q)
      OP_ADD: begin
        res_w = sum_w[MSB:0];
        c_w   = sum_w[WIDTH];
        v_w   = (opa_q[MSB] == opb_q[MSB]) && (sum_w[MSB] != opa_q[MSB]);
      end
      OP_SUB: begin
        res_w = dif_w[MSB:0];
        c_w   = dif_w[WIDTH];
        v_w   = (opa_q[MSB] != opb_q[MSB]) && (dif_w[MSB] != opa_q[MSB]);
      end
      OP_SHL, OP_SHR: res_w = opa_q;
      OP_CMP: begin
        res_w      = '0;
        res_w[2:0] = {opa_q < opb_q, opa_q > opb_q, opa_q == opb_q};
      end
      OP_AND:  res_w = opa_q & opb_q;
      OP_OR:   res_w = opa_q | opb_q;
      OP_XOR:  res_w = opa_q ^ opb_q;
      OP_NAND: res_w = ~(opa_q & opb_q);
      OP_NOR:  res_w = ~(opa_q | opb_q);
      OP_XNOR: res_w = ~(opa_q ^ opb_q);
      OP_INV:  res_w = ~opa_q;
      OP_NEG: begin
        res_w = '0 - opa_q;
        v_w   = (opa_q == {1'b1, {(WIDTH-1){1'b0}}});
      end
      default: wr_w = 1'b0;
    endcase
  end

  always_comb begin
    shn_w      = (op_q == OP_SHL) ? {sh_q[MSB-1:0], 1'b0} : {1'b0, sh_q[MSB:1]};
    shout_w    = (op_q == OP_SHL) ? sh_q[MSB] : sh_q[0];
    is_shift_w = (opcode == 4'(OP_SHL)) || (opcode == 4'(OP_SHR));
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    din_d   = din_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      y_d     = '0;
      flags_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (cmd_valid && cmd_ready) begin
          op_d    = op_e'(opcode);
          dst_d   = dst;
          din_d   = din;
          opa_d   = a_q;
          opb_d   = b_q;
          sh_d    = a_q;
          cnt_d   = b_q[SHW-1:0];
          state_d = (is_shift_w && (b_q[SHW-1:0] != '0)) ? S_SHIFT : S_EXEC;
        end
        S_EXEC: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          unique case (op_q)
            OP_STO:  a_d = y_q;
            OP_SWP: begin
              a_d = opb_q;
              b_d = opa_q;
            end
            OP_LOAD: if (dst_q) b_d = din_q; else a_d = din_q;
            default: ;
          endcase
          if (wr_w) begin
            y_d     = res_w;
            flags_d = {c_w, v_w, res_w[MSB], res_w == '0};
          end
        end
        S_SHIFT: begin
          // The last step writes Y directly from the shifted value.
          sh_d  = shn_w;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            y_d     = shn_w;
            flags_d = {shout_w, 1'b0, shn_w[MSB], shn_w == '0};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      dst_q   <= 1'b0;
      din_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      din_q   <= din_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_calc_core.sv
// Scoreboard bench for alu_calc_core: integer reference model, directed
// board scenarios, abort cases and randomized commands.
module tb_alu_calc_core;

  localparam int W    = 8;
  localparam int M    = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clr = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] din = '0;
  logic         dst = 1'b0;
  logic [W-1:0] a_q, b_q, y_q;
  logic [3:0]   flags;
  logic         busy, done;

  alu_calc_core #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .opcode(opcode), .din(din), .dst(dst),
    .a_q(a_q), .b_q(b_q), .y_q(y_q), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, b, y, f;
    int cyc;
    int busyc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, busy_cnt = 0, done_cnt = 0;
  int   mA = 0, mB = 0, mY = 0, mF = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - (1 << W) : x;
  endfunction

  // Reference model: plain integer arithmetic on the architectural state.
  function automatic void model(input int op, input int d, input bit ds, output exp_t e);
    int a = mA, b = mB, y = 0, c = 0, v = 0, n, s;
    bit wr = 1'b1;
    n = b % W;
    case (op)
      0: begin s = a + b; y = s & M; c = (s >> W) & 1;
               s = sgn(a) + sgn(b); v = (s >= HALF || s < -HALF) ? 1 : 0; end
      1: begin y = (a - b) & M; c = (a < b) ? 1 : 0;
               s = sgn(a) - sgn(b); v = (s >= HALF || s < -HALF) ? 1 : 0; end
      2: begin y = (a << n) & M; c = (n != 0) ? (a >> (W - n)) & 1 : 0; end
      3: begin y = a >> n; c = (n != 0) ? (a >> (n - 1)) & 1 : 0; end
      4: y = ((a < b) ? 4 : 0) + ((a > b) ? 2 : 0) + ((a == b) ? 1 : 0);
      5: y = a & b;
      6: y = a | b;
      7: y = a ^ b;
      8: y = ~(a & b) & M;
      9: y = ~(a | b) & M;
      10: y = ~(a ^ b) & M;
      11: y = ~a & M;
      12: begin y = (0 - a) & M; v = (a == HALF) ? 1 : 0; end
      13: begin wr = 1'b0; mA = mY; end
      14: begin wr = 1'b0; mA = b; mB = a; end
      default: begin wr = 1'b0; if (ds) mB = d; else mA = d; end
    endcase
    if (wr) begin
      mY = y;
      mF = c * 8 + v * 4 + ((y >> (W - 1)) & 1) * 2 + ((y == 0) ? 1 : 0);
    end
    e.a = mA; e.b = mB; e.y = mY; e.f = mF;
    if ((op == 2 || op == 3) && n != 0) begin
      e.cyc = n + 1; e.busyc = n;
    end else begin
      e.cyc = 2; e.busyc = 1;
    end
  endfunction

  task automatic issue(input int op, input int d, input bit ds, input bit track);
    exp_t e;
    int g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1 (t=%0t)", $time);
      return;
    end
    cmd_valid = 1'b1;
    opcode    = 4'(op);
    din       = W'(d);
    dst       = ds;
    if (track) begin
      model(op, d, ds, e);
      e.cyc = cyc + e.cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic zero_model();
    mA = 0; mB = 0; mY = 0; mF = 0;
  endtask

  // Monitor: pops one expectation per retired command.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        me = sb.pop_front();
        check("a_q", 32'(a_q), me.a);
        check("b_q", 32'(b_q), me.b);
        check("y_q", 32'(y_q), me.y);
        check("flags", 32'(flags), me.f);
        check("done_cycle", cyc, me.cyc);
        check("busy_cycles", busy_cnt, me.busyc);
        check("busy_with_done", 32'(busy), 0);
      end
      busy_cnt = 0;
    end else if (busy) busy_cnt++;
    else busy_cnt = 0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, g;
    // Reset held with a pending command.
    cmd_valid = 1'b1; opcode = 4'hF; din = 8'hAA; dst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a", 32'(a_q), 0);
    check("rst_y", 32'(y_q), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_ready", 32'(cmd_ready), 0);
    reset_n = 1'b1;
    cmd_valid = 1'b0;
    #1 check("ready_after_rst", 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    check("no_exec_after_rst", {a_q, b_q}, 0);

    // ADD with carry out.
    issue(15, 'hC8, 0, 1); issue(15, 'h64, 1, 1); issue(0, 0, 0, 1);
    // SUB with borrow, NEG of the most negative value.
    issue(15, 'h05, 0, 1); issue(15, 'h07, 1, 1); issue(1, 0, 0, 1);
    issue(15, 'h80, 0, 1); issue(12, 0, 0, 1);
    // Shifts, including count wrapping to zero.
    issue(15, 'h81, 0, 1); issue(15, 'h03, 1, 1); issue(2, 0, 0, 1);
    issue(15, 'h01, 1, 1); issue(3, 0, 0, 1);
    issue(15, 'h08, 1, 1); issue(2, 0, 0, 1);
    // STO, SWP, CMP.
    issue(15, 'hC8, 0, 1); issue(15, 'h64, 1, 1); issue(0, 0, 0, 1);
    issue(13, 0, 0, 1); issue(14, 0, 0, 1); issue(4, 0, 0, 1);
    repeat (3) @(negedge clk);

    // clr in the same cycle as a would-be accept.
    clr = 1'b1; cmd_valid = 1'b1; opcode = 4'hF; din = 8'h33; dst = 1'b1;
    #1 check("ready_low_in_clr", 32'(cmd_ready), 0);
    @(negedge clk);
    clr = 1'b0; cmd_valid = 1'b0;
    zero_model();
    #1 check("clr_beats_accept", {a_q, b_q, y_q, flags}, 0);

    // clr mid-shift, with a command held during the shift.
    issue(15, 'h5A, 0, 1); issue(15, 'h07, 1, 1);
    issue(2, 0, 0, 0);
    dc = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; opcode = 4'hF; din = 8'hFF; dst = 1'b0;
    check("ready_low_in_shift", 32'(cmd_ready), 0);
    @(negedge clk);
    check("busy_in_shift", 32'(busy), 1);
    cmd_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    zero_model();
    check("clr_abort_regs", {a_q, b_q, y_q, flags}, 0);
    check("clr_abort_busy", 32'(busy), 0);
    repeat (10) @(negedge clk);
    check("clr_abort_no_done", done_cnt, dc);

    // Async reset mid-shift.
    issue(15, 'hA5, 0, 1); issue(15, 'h07, 1, 1);
    issue(2, 0, 0, 0);
    dc = done_cnt;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("rst_abort_regs", {a_q, b_q, y_q, flags}, 0);
    check("rst_abort_busy", {busy, done, cmd_ready}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    zero_model();
    #1 check("ready_after_midrst", 32'(cmd_ready), 1);
    repeat (10) @(negedge clk);
    check("rst_abort_no_done", done_cnt, dc);

    // Randomized commands.
    for (int i = 0; i < 300; i++)
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, M)), 1'($urandom), 1);

    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
